// File: rtl/regfile_param_pkg.sv
// Shared constants for the parameterised register file and its write-count
// status counter.
package regfile_param_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

endpackage

// File: rtl/decoder_en.sv
// Enable-gated address decoder: one-hot of i_addr when i_en, else all-zero.
module decoder_en
  import regfile_param_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic                 i_en,
  output logic [2**ADDR_W-1:0] o_onehot
);

  always_comb begin
    o_onehot         = '0;
    o_onehot[i_addr] = i_en;
  end

endmodule

// File: rtl/regfile_param.sv
// Two-read / one-write register file with optional hardwired zero register,
// optional write-to-read bypass, last-write one-hot and saturating write count.
module regfile_param
  import regfile_param_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 clock,
  input  logic                 ctrl_reset_n,
  input  logic                 ctrl_writeEnable,
  input  logic [ADDR_W-1:0]    ctrl_writeReg,
  input  logic [DATA_W-1:0]    data_writeReg,
  input  logic [ADDR_W-1:0]    ctrl_readRegA,
  input  logic [ADDR_W-1:0]    ctrl_readRegB,
  output logic [DATA_W-1:0]    data_readRegA,
  output logic [DATA_W-1:0]    data_readRegB,
  output logic [2**ADDR_W-1:0] wr_onehot_q,
  output logic [CNT_W-1:0]     wr_count_q
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0]             w_dec;
  logic [DEPTH-1:0]             w_acc;
  logic [DEPTH-1:0][DATA_W-1:0] w_regs;
  logic                         w_byp_en;
  logic                         w_any_acc;
  logic [DEPTH-1:0]             r_onehot;
  logic [CNT_W-1:0]             r_count;

  decoder_en #(
    .ADDR_W (ADDR_W)
  ) u_dec (
    .i_addr   (ctrl_writeReg),
    .i_en     (ctrl_writeEnable),
    .o_onehot (w_dec)
  );

  // A write to the hardwired zero register is refused outright, so it also
  // leaves no trace in the one-hot or the counter.
  always_comb begin
    w_acc = w_dec;
    if (ZERO_REG != 0) w_acc[0] = 1'b0;
  end

  assign w_any_acc = |w_acc;

  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    if ((ZERO_REG != 0) && (g == 0)) begin : g_zero
      assign w_regs[g] = '0;
    end else begin : g_store
      logic [DATA_W-1:0] r_q;
      always_ff @(posedge clock) begin
        if (!ctrl_reset_n)  r_q <= '0;
        else if (w_acc[g])  r_q <= data_writeReg;
      end
      assign w_regs[g] = r_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      r_onehot <= '0;
      r_count  <= '0;
    end else begin
      r_onehot <= w_acc;
      if (w_any_acc && (r_count != CNT_SAT)) r_count <= r_count + 1'b1;
    end
  end

  assign wr_onehot_q = r_onehot;
  assign wr_count_q  = r_count;

  assign w_byp_en = (BYPASS != 0) && ctrl_reset_n && ctrl_writeEnable;

  // Zero-register override is applied last so it beats the bypass path.
  always_comb begin
    data_readRegA = w_regs[ctrl_readRegA];
    if (w_byp_en && (ctrl_writeReg == ctrl_readRegA)) data_readRegA = data_writeReg;
    if ((ZERO_REG != 0) && (ctrl_readRegA == '0))    data_readRegA = '0;
  end

  always_comb begin
    data_readRegB = w_regs[ctrl_readRegB];
    if (w_byp_en && (ctrl_writeReg == ctrl_readRegB)) data_readRegB = data_writeReg;
    if ((ZERO_REG != 0) && (ctrl_readRegB == '0))    data_readRegB = '0;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: default instance plus a ZERO_REG=0/BYPASS=0 instance,
// both checked against an array-based behavioural model.
module tb_regfile_param;

  logic        clock = 1'b0;
  logic        rst_n, we;
  logic [4:0]  wa, ra, rb;
  logic [31:0] wd;

  logic [31:0] ra0, rb0, oh0, ra1, rb1, oh1;
  logic [15:0] cnt0, cnt1;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] m0 [32];
  logic [31:0] m1 [32];
  logic [31:0] h0, h1;
  logic [15:0] c0, c1;

  always #5 clock = ~clock;

  regfile_param dut (
    .clock(clock), .ctrl_reset_n(rst_n), .ctrl_writeEnable(we),
    .ctrl_writeReg(wa), .data_writeReg(wd),
    .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(ra0), .data_readRegB(rb0),
    .wr_onehot_q(oh0), .wr_count_q(cnt0)
  );

  regfile_param #(.ADDR_W(5), .DATA_W(32), .ZERO_REG(0), .BYPASS(0)) dut_alt (
    .clock(clock), .ctrl_reset_n(rst_n), .ctrl_writeEnable(we),
    .ctrl_writeReg(wa), .data_writeReg(wd),
    .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(ra1), .data_readRegB(rb1),
    .wr_onehot_q(oh1), .wr_count_q(cnt1)
  );

  // Expected reads: default instance (zero reg, bypass) and alt (plain storage).
  function automatic logic [31:0] exp0(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (rst_n && we && (wa == a)) return wd;
    return m0[a];
  endfunction

  function automatic logic [31:0] exp1(input logic [4:0] a);
    return m1[a];
  endfunction

  task automatic drive(input logic r, input logic w, input logic [4:0] a,
                       input logic [31:0] d, input logic [4:0] xa, input logic [4:0] xb);
    @(negedge clock);
    rst_n = r; we = w; wa = a; wd = d; ra = xa; rb = xb;
    #1;
  endtask

  task automatic tick;
    @(posedge clock);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin m0[i] = 32'h0; m1[i] = 32'h0; end
      h0 = 32'h0; h1 = 32'h0; c0 = 16'h0; c1 = 16'h0;
    end else begin
      if (we && wa != 5'd0) begin
        m0[wa] = wd; h0 = 32'h1 << wa;
        c0 = (c0 == 16'hFFFF) ? c0 : c0 + 16'h1;
      end else h0 = 32'h0;
      if (we) begin
        m1[wa] = wd; h1 = 32'h1 << wa;
        c1 = (c1 == 16'hFFFF) ? c1 : c1 + 16'h1;
      end else h1 = 32'h0;
    end
    #1;
  endtask

  task automatic test_reset;
    drive(1'b0, 1'b1, 5'd3, 32'h1111_2222, 5'd3, 5'd3);
    tick();
    n_total++; if (cnt0 !== 16'h0) $display("FAIL reset_cnt0 got=%h exp=0", cnt0); else n_pass++;
    n_total++; if (oh0 !== 32'h0)  $display("FAIL reset_oh0 got=%h exp=0", oh0); else n_pass++;
    n_total++; if (cnt1 !== 16'h0) $display("FAIL reset_cnt1 got=%h exp=0", cnt1); else n_pass++;
    // bypass suppressed in reset: all addresses read stored zero
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b1, 5'(i), 32'hCAFE_0000 + i, 5'(i), 5'(31 - i));
      n_total++; if (ra0 !== 32'h0) $display("FAIL reset_readA0 addr=%0d got=%h exp=0", i, ra0); else n_pass++;
      n_total++; if (rb0 !== 32'h0) $display("FAIL reset_readB0 addr=%0d got=%h exp=0", 31 - i, rb0); else n_pass++;
      n_total++; if (ra1 !== 32'h0) $display("FAIL reset_readA1 addr=%0d got=%h exp=0", i, ra1); else n_pass++;
      tick();
    end
  endtask

  task automatic test_decode_sweep;
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b1, 5'(i), 32'h1 << i, 5'd0, 5'd0);
      tick();
      n_total++; if (oh0 !== ((i == 0) ? 32'h0 : (32'h1 << i)))
        $display("FAIL sweep_onehot0 addr=%0d got=%h exp=%h", i, oh0, h0); else n_pass++;
      n_total++; if (oh1 !== (32'h1 << i))
        $display("FAIL sweep_onehot1 addr=%0d got=%h exp=%h", i, oh1, 32'h1 << i); else n_pass++;
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i));
      n_total++; if (ra0 !== ((i == 0) ? 32'h0 : (32'h1 << i)))
        $display("FAIL sweep_readA0 addr=%0d got=%h exp=%h", i, ra0, exp0(5'(i))); else n_pass++;
      n_total++; if (rb0 !== exp0(5'(i)))
        $display("FAIL sweep_readB0 addr=%0d got=%h exp=%h", i, rb0, exp0(5'(i))); else n_pass++;
      n_total++; if (ra1 !== (32'h1 << i))
        $display("FAIL sweep_readA1 addr=%0d got=%h exp=%h", i, ra1, 32'h1 << i); else n_pass++;
    end
    n_total++; if (cnt0 !== 16'd31) $display("FAIL sweep_cnt0 got=%0d exp=31", cnt0); else n_pass++;
    n_total++; if (cnt1 !== 16'd32) $display("FAIL sweep_cnt1 got=%0d exp=32", cnt1); else n_pass++;
  endtask

  task automatic test_bypass;
    drive(1'b1, 1'b1, 5'd7, 32'hAAAA_0000, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd6);
    n_total++; if (ra0 !== 32'h1234_5678) $display("FAIL bypass_same_cycle0 got=%h exp=12345678", ra0); else n_pass++;
    n_total++; if (ra1 !== 32'hAAAA_0000) $display("FAIL bypass_off_old1 got=%h exp=aaaa0000", ra1); else n_pass++;
    n_total++; if (rb0 !== 32'h1 << 6)    $display("FAIL bypass_other_port0 got=%h exp=%h", rb0, 32'h1 << 6); else n_pass++;
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    n_total++; if (ra1 !== 32'h1234_5678) $display("FAIL bypass_off_next1 got=%h exp=12345678", ra1); else n_pass++;
    n_total++; if (rb0 !== 32'h1234_5678) $display("FAIL bypass_stored0 got=%h exp=12345678", rb0); else n_pass++;
  endtask

  task automatic test_zero_reg;
    logic [15:0] prev0, prev1;
    prev0 = c0; prev1 = c1;
    drive(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    n_total++; if (ra0 !== 32'h0) $display("FAIL zero_bypass0 got=%h exp=0", ra0); else n_pass++;
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    n_total++; if (ra0 !== 32'h0)         $display("FAIL zero_read0 got=%h exp=0", ra0); else n_pass++;
    n_total++; if (cnt0 !== prev0)        $display("FAIL zero_cnt0 got=%0d exp=%0d", cnt0, prev0); else n_pass++;
    n_total++; if (oh0 !== 32'h0)         $display("FAIL zero_onehot0 got=%h exp=0", oh0); else n_pass++;
    n_total++; if (ra1 !== 32'hFFFF_FFFF) $display("FAIL zero_read1 got=%h exp=ffffffff", ra1); else n_pass++;
    n_total++; if (cnt1 !== prev1 + 16'h1) $display("FAIL zero_cnt1 got=%0d exp=%0d", cnt1, prev1 + 16'h1); else n_pass++;
    n_total++; if (oh1 !== 32'h1)         $display("FAIL zero_onehot1 got=%h exp=1", oh1); else n_pass++;
  endtask

  task automatic test_reset_collision;
    drive(1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF, 5'd3, 5'd3);
    n_total++; if (ra0 !== 32'h1 << 3) $display("FAIL coll_no_bypass0 got=%h exp=%h", ra0, 32'h1 << 3); else n_pass++;
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    n_total++; if (ra0 !== 32'h0)  $display("FAIL coll_reg3_0 got=%h exp=0", ra0); else n_pass++;
    n_total++; if (rb1 !== 32'h0)  $display("FAIL coll_reg3_1 got=%h exp=0", rb1); else n_pass++;
    n_total++; if (cnt0 !== 16'h0) $display("FAIL coll_cnt0 got=%0d exp=0", cnt0); else n_pass++;
    n_total++; if (oh0 !== 32'h0)  $display("FAIL coll_onehot0 got=%h exp=0", oh0); else n_pass++;
  endtask

  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a, xa, xb;
      a  = 5'($urandom_range(0, 31));
      xa = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
      xb = ($urandom_range(0, 3) == 0) ? xa : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)), a, $urandom, xa, xb);
      n_total++; if (ra0 !== exp0(ra)) $display("FAIL rand_readA0 n=%0d got=%h exp=%h", n, ra0, exp0(ra)); else n_pass++;
      n_total++; if (rb0 !== exp0(rb)) $display("FAIL rand_readB0 n=%0d got=%h exp=%h", n, rb0, exp0(rb)); else n_pass++;
      n_total++; if (ra1 !== exp1(ra)) $display("FAIL rand_readA1 n=%0d got=%h exp=%h", n, ra1, exp1(ra)); else n_pass++;
      n_total++; if (rb1 !== exp1(rb)) $display("FAIL rand_readB1 n=%0d got=%h exp=%h", n, rb1, exp1(rb)); else n_pass++;
      if (ra == rb) begin
        n_total++; if (ra0 !== rb0) $display("FAIL rand_same_addr n=%0d A=%h B=%h", n, ra0, rb0); else n_pass++;
      end
      tick();
      n_total++; if (oh0 !== h0)  $display("FAIL rand_onehot0 n=%0d got=%h exp=%h", n, oh0, h0); else n_pass++;
      n_total++; if (cnt0 !== c0) $display("FAIL rand_cnt0 n=%0d got=%0d exp=%0d", n, cnt0, c0); else n_pass++;
      n_total++; if (oh1 !== h1)  $display("FAIL rand_onehot1 n=%0d got=%h exp=%h", n, oh1, h1); else n_pass++;
      n_total++; if (cnt1 !== c1) $display("FAIL rand_cnt1 n=%0d got=%0d exp=%0d", n, cnt1, c1); else n_pass++;
    end
  endtask

  task automatic test_midrun_reset;
    for (int n = 0; n < 10; n++) begin
      drive(1'b1, 1'b1, 5'($urandom_range(1, 31)), $urandom | 32'h1, 5'd0, 5'd0);
      tick();
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 5'd9, 32'h55, 5'd0, 5'd0);
    tick();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i));
      n_total++; if (ra0 !== ((i == 9) ? 32'h55 : 32'h0))
        $display("FAIL midrst_read0 addr=%0d got=%h exp=%h", i, ra0, exp0(5'(i))); else n_pass++;
      n_total++; if (rb1 !== ((i == 9) ? 32'h55 : 32'h0))
        $display("FAIL midrst_read1 addr=%0d got=%h exp=%h", i, rb1, exp1(5'(i))); else n_pass++;
    end
    n_total++; if (cnt0 !== 16'd1) $display("FAIL midrst_cnt0 got=%0d exp=1", cnt0); else n_pass++;
    n_total++; if (cnt1 !== 16'd1) $display("FAIL midrst_cnt1 got=%0d exp=1", cnt1); else n_pass++;
  endtask

  task automatic test_saturation;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    tick();
    for (int k = 1; k <= 65540; k++) begin
      drive(1'b1, 1'b1, 5'd5, 32'(k), 5'd5, 5'd0);
      tick();
      if (k == 65534 || k == 65535 || k == 65540) begin
        n_total++; if (cnt0 !== ((k < 65535) ? 16'(k) : 16'hFFFF))
          $display("FAIL sat_cnt0 writes=%0d got=%h exp=%h", k, cnt0, c0); else n_pass++;
        n_total++; if (cnt1 !== c1)
          $display("FAIL sat_cnt1 writes=%0d got=%h exp=%h", k, cnt1, c1); else n_pass++;
      end
    end
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    n_total++; if (ra0 !== 32'd65540) $display("FAIL sat_reg5 got=%0d exp=65540", ra0); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = '0; rb = '0;
    for (int i = 0; i < 32; i++) begin m0[i] = 32'h0; m1[i] = 32'h0; end
    h0 = '0; h1 = '0; c0 = '0; c1 = '0;
    test_reset();
    test_decode_sweep();
    test_bypass();
    test_zero_reg();
    test_reset_collision();
    test_random();
    test_midrun_reset();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
